// File: rtl/master_port_adapter.sv
// Per-master crossbar front end: buffers client requests in a FIFO and
// issues them one at a time, returning completion, read data or timeout.
module master_port_adapter #(
    parameter int DW      = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_cmd,
    input  logic [31:0]   in_addr,
    input  logic [DW-1:0] in_wdata,
    output logic          out_valid,
    output logic          out_cmd,
    output logic [DW-1:0] out_rdata,
    output logic          out_err,
    output logic          req,
    output logic          cmd,
    output logic [31:0]   addr,
    output logic [DW-1:0] wdata,
    input  logic          ack,
    input  logic          resp,
    input  logic [DW-1:0] rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_RESP
    } state_t;

    logic          r_mem_cmd   [DEPTH];
    logic [31:0]   r_mem_addr  [DEPTH];
    logic [DW-1:0] r_mem_wdata [DEPTH];

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    state_t        r_state;
    logic [TW-1:0] r_timer;

    logic          r_req;
    logic          r_cmd;
    logic [31:0]   r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_out_valid;
    logic          r_out_cmd;
    logic [DW-1:0] r_out_rdata;
    logic          r_out_err;

    logic w_full;
    logic w_push;
    logic w_ack_ev;
    logic w_resp_ev;
    logic w_tmo;
    logic w_pop;

    assign w_full    = (r_count == FULL);
    assign w_push    = in_valid && !w_full;
    assign w_ack_ev  = (r_state == WAIT_ACK) && ack;
    assign w_resp_ev = (r_state == WAIT_RESP) && resp;

    // An ack/resp arriving in the last allowed cycle beats the timeout.
    assign w_tmo = (r_state != IDLE) && (r_timer == TMAX)
                && !w_ack_ev && !w_resp_ev;

    // Head leaves the FIFO only once its transaction is finished.
    assign w_pop = (w_ack_ev && r_cmd) || w_resp_ev || w_tmo;

    assign in_ready  = !w_full;
    assign req       = r_req;
    assign cmd       = r_cmd;
    assign addr      = r_addr;
    assign wdata     = r_wdata;
    assign out_valid = r_out_valid;
    assign out_cmd   = r_out_cmd;
    assign out_rdata = r_out_rdata;
    assign out_err   = r_out_err;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_cmd[r_wptr]   <= in_cmd;
            r_mem_addr[r_wptr]  <= in_addr;
            r_mem_wdata[r_wptr] <= in_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_req       <= 1'b0;
            r_cmd       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_out_valid <= 1'b0;
            r_out_cmd   <= 1'b0;
            r_out_rdata <= '0;
            r_out_err   <= 1'b0;
        end else begin
            r_req       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_count != '0) begin
                        r_req   <= 1'b1;
                        r_cmd   <= r_mem_cmd[r_rptr];
                        r_addr  <= r_mem_addr[r_rptr];
                        r_wdata <= r_mem_wdata[r_rptr];
                        r_timer <= '0;
                        r_state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack) begin
                        if (r_cmd) begin
                            r_out_valid <= 1'b1;
                            r_out_cmd   <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            r_timer <= '0;
                            r_state <= WAIT_RESP;
                        end
                    end else if (r_timer == TMAX) begin
                        r_out_valid <= 1'b1;
                        r_out_err   <= 1'b1;
                        r_out_cmd   <= r_cmd;
                        r_state     <= IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                WAIT_RESP: begin
                    if (resp) begin
                        r_out_valid <= 1'b1;
                        r_out_cmd   <= 1'b0;
                        r_out_rdata <= rdata;
                        r_state     <= IDLE;
                    end else if (r_timer == TMAX) begin
                        r_out_valid <= 1'b1;
                        r_out_err   <= 1'b1;
                        r_out_cmd   <= r_cmd;
                        r_state     <= IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_master_port_adapter.sv
// Scoreboard bench for master_port_adapter: driver, crossbar slave model
// and an output monitor run as independent processes.
module tb_master_port_adapter;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;
    localparam int NONE  = 8;
    localparam int RST   = 9;

    typedef struct {
        logic        cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
    } iss_t;

    typedef struct {
        logic        cmd;
        logic        err;
        logic [31:0] rd;
        int          cyc;
    } exp_t;

    typedef struct {
        int          d;
        int          e;
        logic [31:0] rd;
    } scr_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_cmd;
    logic [31:0]   in_addr;
    logic [DW-1:0] in_wdata;
    logic          out_valid;
    logic          out_cmd;
    logic [DW-1:0] out_rdata;
    logic          out_err;
    logic          req;
    logic          cmd;
    logic [31:0]   addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic          resp;
    logic [DW-1:0] rdata;

    iss_t iss_q[$];
    exp_t exp_q[$];
    scr_t scr_q[$];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          pushes = 0;
    int          comps = 0;
    logic        prev_req = 1'b0;
    logic        mon_en = 1'b0;
    logic        slave_busy = 1'b0;
    logic [31:0] last_rd = '0;

    master_port_adapter #(
        .DW(DW),
        .DEPTH(DEPTH),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_cmd(in_cmd),
        .in_addr(in_addr),
        .in_wdata(in_wdata),
        .out_valid(out_valid),
        .out_cmd(out_cmd),
        .out_rdata(out_rdata),
        .out_err(out_err),
        .req(req),
        .cmd(cmd),
        .addr(addr),
        .wdata(wdata),
        .ack(ack),
        .resp(resp),
        .rdata(rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_outputs(string nm);
        chk({nm, "_req"}, 64'(req), 64'(0));
        chk({nm, "_cmd"}, 64'(cmd), 64'(0));
        chk({nm, "_addr"}, 64'(addr), 64'(0));
        chk({nm, "_wdata"}, 64'(wdata), 64'(0));
        chk({nm, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({nm, "_out_cmd"}, 64'(out_cmd), 64'(0));
        chk({nm, "_out_rdata"}, 64'(out_rdata), 64'(0));
        chk({nm, "_out_err"}, 64'(out_err), 64'(0));
        chk({nm, "_in_ready"}, 64'(in_ready), 64'(1));
    endtask

    // Monitor: completions against the scoreboard, FIFO occupancy model.
    initial begin
        exp_t e;
        iss_t t;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (req) begin
                    chk("req_one_cycle", 64'(prev_req), 64'(0));
                end
                prev_req = req;
                if (out_valid) begin
                    comps++;
                    if (exp_q.size() == 0) begin
                        chk("spurious_out_valid", 64'(out_valid), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_cmd", 64'(out_cmd), 64'(e.cmd));
                        chk("out_err", 64'(out_err), 64'(e.err));
                        if (!e.cmd) begin
                            chk("out_rdata", 64'(out_rdata), 64'(e.rd));
                        end
                        chk("out_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
                chk("in_ready", 64'(in_ready),
                    64'((pushes - comps) < DEPTH));
                if (in_valid && in_ready) begin
                    pushes++;
                    t.cmd   = in_cmd;
                    t.addr  = in_addr;
                    t.wdata = in_wdata;
                    iss_q.push_back(t);
                end
            end
        end
    end

    // Crossbar slave model: checks each issue, decides the response timing.
    initial begin
        iss_t t;
        exp_t e;
        scr_t s;
        int   r;
        int   a;
        ack   = 1'b0;
        resp  = 1'b0;
        rdata = '0;
        forever begin
            @(negedge clk);
            if (mon_en && req) begin
                slave_busy = 1'b1;
                r = cyc;
                if (iss_q.size() == 0) begin
                    chk("unexpected_req", 64'(req), 64'(0));
                end else begin
                    t = iss_q.pop_front();
                    chk("issue_cmd", 64'(cmd), 64'(t.cmd));
                    chk("issue_addr", 64'(addr), 64'(t.addr));
                    chk("issue_wdata", 64'(wdata), 64'(t.wdata));
                    if (scr_q.size() != 0) begin
                        s = scr_q.pop_front();
                    end else begin
                        s.d  = ($urandom_range(0, 15) == 0)
                             ? NONE : int'($urandom_range(0, 7));
                        s.e  = ($urandom_range(0, 15) == 0)
                             ? NONE : int'($urandom_range(0, 7));
                        s.rd = $urandom;
                    end
                    if (s.d == NONE) begin
                        e.cmd = t.cmd;
                        e.err = 1'b1;
                        e.rd  = last_rd;
                        e.cyc = r + TMO;
                        exp_q.push_back(e);
                    end else begin
                        repeat (s.d) @(negedge clk);
                        ack = 1'b1;
                        a = cyc;
                        if (t.cmd) begin
                            e.cmd = 1'b1;
                            e.err = 1'b0;
                            e.rd  = '0;
                            e.cyc = a + 1;
                            exp_q.push_back(e);
                        end
                        @(negedge clk);
                        ack = 1'b0;
                        if (!t.cmd && s.e == NONE) begin
                            e.cmd = 1'b0;
                            e.err = 1'b1;
                            e.rd  = last_rd;
                            e.cyc = a + 1 + TMO;
                            exp_q.push_back(e);
                        end else if (!t.cmd && s.e == RST) begin
                            repeat (2) @(negedge clk);
                            #2 rst_n = 1'b0;
                            #1 chk_reset_outputs("midrst");
                            iss_q.delete();
                            exp_q.delete();
                            pushes   = 0;
                            comps    = 0;
                            prev_req = 1'b0;
                            last_rd  = '0;
                            @(negedge clk);
                            #2 rst_n = 1'b1;
                            @(negedge clk);
                            resp  = 1'b1;
                            rdata = $urandom;
                            @(negedge clk);
                            resp = 1'b0;
                            ack  = 1'b1;
                            @(negedge clk);
                            ack = 1'b0;
                            repeat (3) @(negedge clk);
                        end else if (!t.cmd) begin
                            repeat (s.e) @(negedge clk);
                            resp  = 1'b1;
                            rdata = s.rd;
                            e.cmd = 1'b0;
                            e.err = 1'b0;
                            e.rd  = s.rd;
                            e.cyc = cyc + 1;
                            exp_q.push_back(e);
                            last_rd = s.rd;
                            @(negedge clk);
                            resp  = 1'b0;
                            rdata = $urandom;
                        end
                    end
                end
                slave_busy = 1'b0;
            end
        end
    end

    task automatic send(logic c, logic [31:0] a, logic [31:0] w);
        int   k;
        logic acc;
        k = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_cmd   = c;
        in_addr  = a;
        in_wdata = w;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            k++;
        end while (!acc && k < 200);
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL send_accept: got 0 expected 1 (cycle %0d)", cyc);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (!(iss_q.size() == 0 && exp_q.size() == 0 && !slave_busy
                 && pushes == comps) && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 3000) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got busy expected idle (cycle %0d)", cyc);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic script(int d, int e, logic [31:0] rd);
        scr_t s;
        s.d  = d;
        s.e  = e;
        s.rd = rd;
        scr_q.push_back(s);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_cmd   = 1'b0;
        in_addr  = '0;
        in_wdata = '0;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        script(3, 0, '0);
        send(1'b1, 32'h4000_0010, 32'hDEAD_BEEF);
        drain();

        script(1, 2, 32'h1234_5678);
        send(1'b0, 32'h8000_0004, 32'h0);
        drain();

        script(7, 0, '0);
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 32'h1000_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i));
        end
        drain();

        script(NONE, 0, '0);
        script(2, 0, '0);
        send(1'b1, 32'h2000_0100, 32'h5555_AAAA);
        send(1'b1, 32'h2000_0104, 32'hAAAA_5555);
        drain();

        script(1, NONE, '0);
        send(1'b0, 32'hC000_0040, 32'h0);
        drain();

        script(7, 7, 32'hCAFE_F00D);
        send(1'b0, 32'h8000_0008, 32'h0);
        drain();

        script(0, RST, 32'h0);
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 32'h9000_0000 + 32'(i * 4), 32'h0);
        end
        drain();

        for (int i = 0; i < 60; i++) begin
            send(1'($urandom), $urandom, $urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
